rx_state_machine: RTL and testbench
===================================

RX_STATE_MACHINE -- requirements
Module: rx_state_machine

Interface
REQ-001 Parameter DATA_BITS, default 8: number of UART data bits per frame, LSB first.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 serial_in  input  1  raw UART Rx line; idle high; asynchronous to clk.
REQ-005 sampling_strobe  input  1  single-cycle mid-bit pulse from the sampling strobe generator.
REQ-006 start_detected  output  1  single-cycle pulse that re-aligns the sampling strobe generator to the start bit.
REQ-007 rx_data  output  DATA_BITS  last accepted byte.
REQ-008 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-009 rx_ready  input  1  consumer accepts rx_data when rx_valid and rx_ready are both high in the same cycle.
REQ-010 framing_error  output  1  single-cycle pulse: stop bit sampled low.
REQ-011 overrun_error  output  1  single-cycle pulse: a frame completed while rx_valid was still high.

Function
REQ-012 serial_in SHALL pass through a 2-flop synchronizer (both flops reset to 1); rx_s is the second-flop output, and rx_s_d is rx_s delayed by one cycle.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP; the encoding is free.
REQ-014 IDLE: when rx_s_d==1 and rx_s==0 (falling edge), the FSM SHALL pulse start_detected for exactly one cycle and enter START.
REQ-015 start_detected SHALL be asserted only in the cycle that leaves IDLE; it is never asserted in any other state.
REQ-016 In IDLE, sampling_strobe SHALL be ignored.
REQ-017 START: on sampling_strobe with rx_s==0, the FSM SHALL enter DATA and clear the bit counter; with rx_s==1 (glitch or false start), it SHALL return to IDLE without any output pulse.
REQ-018 DATA: on each sampling_strobe, rx_s SHALL be shifted into the shift register MSB end (LSB-first reception) and the bit counter incremented.
REQ-019 After the DATA_BITS-th strobe in DATA, the FSM SHALL enter STOP.
REQ-020 The bit counter SHALL be $clog2(DATA_BITS+1) bits wide and SHALL never wrap.
REQ-021 STOP, on sampling_strobe with rx_s==1, rx_valid==0, or rx_valid and rx_ready both high: the FSM SHALL copy the shift register to rx_data, set rx_valid, and go to IDLE.
REQ-022 STOP, on sampling_strobe with rx_s==1, rx_valid==1 and rx_ready==0: the FSM SHALL keep the old rx_data, pulse overrun_error for one cycle, and go to IDLE.
REQ-023 STOP, on sampling_strobe with rx_s==0: the FSM SHALL pulse framing_error for one cycle, leave rx_data and rx_valid unchanged, and go to IDLE.
REQ-024 After a framing error, a new falling edge SHALL be required before the next frame starts.
REQ-025 rx_valid SHALL clear in the cycle after an rx_valid and rx_ready handshake, unless REQ-021 sets it in the same cycle (load wins).
REQ-026 rx_ready SHALL have no effect while rx_valid==0.
REQ-027 Between sampling_strobe pulses the FSM SHALL hold its state; no timeout is provided.
REQ-028 framing_error and overrun_error SHALL never be high in the same cycle.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 While reset_n==0: FSM=IDLE, both synchronizer flops=1, rx_s_d=1, shift register=0, bit counter=0, rx_data=0, rx_valid=0, start_detected=0, framing_error=0, overrun_error=0.
REQ-031 Asserting reset_n mid-frame SHALL abort the frame with no output pulse.
REQ-032 After reset_n deasserts, a line already low SHALL NOT count as a falling edge; detection requires a high-to-low transition.

Verification (bench instantiates the sampling strobe generator with CLOCKS_PER_BIT=8)
REQ-033 Frame 0xA5 with a good stop bit, rx_ready=0 -> exactly one start_detected pulse, rx_data=0xA5, rx_valid=1 one cycle after the stop-bit strobe, no error pulses.
REQ-034 Low glitch of 2 clk on idle line -> START aborts at the first strobe, rx_valid stays 0, no error pulses, FSM returns to IDLE.
REQ-035 Frame 0x3C with stop bit 0 -> framing_error pulses for 1 cycle, rx_valid and rx_data unchanged.
REQ-036 Frame 0x11 accepted, rx_ready held 0, then frame 0x22 -> overrun_error pulses once, rx_data stays 0x11; raising rx_ready then clears rx_valid next cycle.
REQ-037 Back-to-back frames 0x00 and 0xFF with rx_ready=1 throughout -> two rx_valid loads with the correct values, no errors.
REQ-038 reset_n pulsed low during bit 4 of a frame -> all outputs return to reset values, no rx_valid; the next clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/rx_state_machine.sv
// UART receive state machine: synchronises the Rx line, frames LSB-first
// bytes on external mid-bit strobes and flags framing and overrun errors.
module rx_state_machine #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 serial_in,
    input  logic                 sampling_strobe,
    output logic                 start_detected,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 framing_error,
    output logic                 overrun_error
);

    localparam int CW = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state, state_nx;

    logic                 sync1, rx_s, rx_s_d;
    logic [2:0]           prime;
    logic                 fall;
    logic [DATA_BITS-1:0] shreg, shreg_nx, data_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic                 valid_nx, sd_nx, fe_nx, oe_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
            prime  <= '0;
        end else begin
            sync1  <= serial_in;
            rx_s   <= sync1;
            rx_s_d <= rx_s;
            prime  <= {prime[1:0], 1'b1};
        end
    end

    // Edges only count once the pipe holds real samples, so a line that
    // is already low when reset releases is not mistaken for a start bit.
    assign fall = prime[2] && rx_s_d && !rx_s;

    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        data_nx  = rx_data;
        valid_nx = rx_valid && !rx_ready;
        sd_nx    = 1'b0;
        fe_nx    = 1'b0;
        oe_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    sd_nx    = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                if (sampling_strobe) begin
                    if (!rx_s) begin
                        state_nx = DATA;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            DATA: begin
                if (sampling_strobe) begin
                    shreg_nx = DATA_BITS'({rx_s, shreg} >> 1);
                    cnt_nx   = cnt + CW'(1);
                    if (cnt == CW'(DATA_BITS - 1)) begin
                        state_nx = STOP;
                    end
                end
            end
            STOP: begin
                if (sampling_strobe) begin
                    state_nx = IDLE;
                    if (!rx_s) begin
                        fe_nx = 1'b1;
                    end else if (!rx_valid || rx_ready) begin
                        data_nx  = shreg;
                        valid_nx = 1'b1;
                    end else begin
                        oe_nx = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            shreg          <= '0;
            cnt            <= '0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            start_detected <= 1'b0;
            framing_error  <= 1'b0;
            overrun_error  <= 1'b0;
        end else begin
            state          <= state_nx;
            shreg          <= shreg_nx;
            cnt            <= cnt_nx;
            rx_data        <= data_nx;
            rx_valid       <= valid_nx;
            start_detected <= sd_nx;
            framing_error  <= fe_nx;
            overrun_error  <= oe_nx;
        end
    end

endmodule

// File: tb/tb_rx_state_machine.sv
// Bench for rx_state_machine: frame-level reference model, per-cycle
// comparison, directed scenarios and randomized frames.
module tb_rx_state_machine;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       serial_in = 1'b1;
    logic       sampling_strobe;
    logic       rx_ready = 1'b0;
    logic       start_detected;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_error;
    logic       overrun_error;

    always #5 clk = ~clk;

    rx_state_machine #(.DATA_BITS(8)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .serial_in       (serial_in),
        .sampling_strobe (sampling_strobe),
        .start_detected  (start_detected),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .framing_error   (framing_error),
        .overrun_error   (overrun_error)
    );

    // Strobe generator, 8 clocks per bit, realigned by start_detected.
    int gen_cnt = 0;
    always @(posedge clk) gen_cnt <= start_detected ? 0 : gen_cnt + 1;
    assign sampling_strobe = (gen_cnt[2:0] == 3'd2) && !start_detected;

    typedef struct {
        int         s;
        logic [7:0] d;
        logic       stop;
        logic       frame;
    } pend_t;

    pend_t q[$];
    pend_t mp;
    int    cyc = 0;
    logic [7:0] exp_data = 8'h00;
    logic exp_valid = 1'b0;
    logic exp_sd = 1'b0;
    logic exp_fe = 1'b0;
    logic exp_oe = 1'b0;
    logic hs;

    // Frame-level model: line falls after edge s; start pulse follows
    // edge s+3, the stop-bit sample lands on edge s+79.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_data  = 8'h00;
            exp_valid = 1'b0;
            exp_sd    = 1'b0;
            exp_fe    = 1'b0;
            exp_oe    = 1'b0;
            q.delete();
        end else begin
            cyc++;
            hs     = exp_valid && rx_ready;
            exp_sd = 1'b0;
            exp_fe = 1'b0;
            exp_oe = 1'b0;
            if (q.size() > 0) begin
                mp = q[0];
                if (cyc == mp.s + 3) exp_sd = 1'b1;
                if (!mp.frame && cyc == mp.s + 3) begin
                    void'(q.pop_front());
                end else if (mp.frame && cyc == mp.s + 79) begin
                    void'(q.pop_front());
                    if (!mp.stop) begin
                        exp_fe = 1'b1;
                    end else if (!exp_valid || rx_ready) begin
                        exp_data = mp.d;
                        hs = 1'b0;
                        exp_valid = 1'b1;
                    end else begin
                        exp_oe = 1'b1;
                    end
                end
            end
            if (hs) exp_valid = 1'b0;
        end
    end

    int passed = 0;
    int total = 0;
    int nprint = 0;
    int n_sd = 0, n_fe = 0, n_oe = 0, n_hs = 0;
    logic running = 1'b0;

    initial forever begin
        @(negedge clk);
        if (running) begin
            total++;
            if ({rx_data, rx_valid, start_detected, framing_error, overrun_error}
                === {exp_data, exp_valid, exp_sd, exp_fe, exp_oe}) begin
                passed++;
            end else if (nprint < 20) begin
                nprint++;
                $display("FAIL cycle %0d: dut data=%h v=%b sd=%b fe=%b oe=%b, need data=%h v=%b sd=%b fe=%b oe=%b",
                         cyc, rx_data, rx_valid, start_detected, framing_error,
                         overrun_error, exp_data, exp_valid, exp_sd, exp_fe, exp_oe);
            end
            n_sd += int'(start_detected);
            n_fe += int'(framing_error);
            n_oe += int'(overrun_error);
            n_hs += int'(rx_valid && rx_ready);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int abort_bit);
        pend_t e;
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        @(posedge clk);
        #1;
        e.s = cyc; e.d = d; e.stop = stop; e.frame = 1'b1;
        q.push_back(e);
        for (int k = 0; k < 10; k++) begin
            serial_in = bits[k];
            if (k == abort_bit) begin
                idle(3);
                reset_n = 1'b0;
                serial_in = 1'b1;
                idle(2);
                reset_n = 1'b1;
                return;
            end
            idle(8);
        end
        serial_in = 1'b1;
        if (!stop) idle(4);
    endtask

    task automatic glitch();
        pend_t e;
        @(posedge clk);
        #1;
        e.s = cyc; e.d = 8'h00; e.stop = 1'b0; e.frame = 1'b0;
        q.push_back(e);
        serial_in = 1'b0;
        idle(2);
        serial_in = 1'b1;
        idle(12);
    endtask

    int sd0, fe0, oe0, hs0;
    logic done = 1'b0;

    initial begin
        idle(3);
        running = 1'b1;
        chk("reset rx_data", int'(rx_data), 0);
        chk("reset rx_valid", int'(rx_valid), 0);
        chk("reset pulses", int'({start_detected, framing_error, overrun_error}), 0);
        reset_n = 1'b1;
        idle(6);

        sd0 = n_sd; fe0 = n_fe; oe0 = n_oe;
        send_frame(8'hA5, 1'b1, -1);
        chk("A5 data", int'(rx_data), 'hA5);
        chk("A5 model data", int'(exp_data), 'hA5);
        chk("A5 valid", int'(rx_valid), 1);
        chk("A5 start pulses", n_sd - sd0, 1);
        chk("A5 errors", (n_fe - fe0) + (n_oe - oe0), 0);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        chk("consume clears valid", int'(rx_valid), 0);

        sd0 = n_sd; fe0 = n_fe; oe0 = n_oe;
        glitch();
        chk("glitch valid", int'(rx_valid), 0);
        chk("glitch start pulses", n_sd - sd0, 1);
        chk("glitch errors", (n_fe - fe0) + (n_oe - oe0), 0);

        fe0 = n_fe;
        send_frame(8'h3C, 1'b0, -1);
        chk("framing pulses", n_fe - fe0, 1);
        chk("framing data kept", int'(rx_data), 'hA5);
        chk("framing valid kept", int'(rx_valid), 0);
        idle(4);

        oe0 = n_oe;
        send_frame(8'h11, 1'b1, -1);
        chk("0x11 data", int'(rx_data), 'h11);
        send_frame(8'h22, 1'b1, -1);
        chk("overrun pulses", n_oe - oe0, 1);
        chk("overrun data kept", int'(rx_data), 'h11);
        chk("overrun valid", int'(rx_valid), 1);
        rx_ready = 1'b1;
        idle(1);
        chk("ready clears valid", int'(rx_valid), 0);

        hs0 = n_hs; fe0 = n_fe; oe0 = n_oe;
        send_frame(8'h00, 1'b1, -1);
        chk("b2b 0x00", int'(rx_data), 'h00);
        send_frame(8'hFF, 1'b1, -1);
        chk("b2b 0xFF", int'(rx_data), 'hFF);
        idle(2);
        chk("b2b handshakes", n_hs - hs0, 2);
        chk("b2b errors", (n_fe - fe0) + (n_oe - oe0), 0);

        rx_ready = 1'b0;
        send_frame(8'h96, 1'b1, 4);
        chk("abort rx_data", int'(rx_data), 0);
        chk("abort rx_valid", int'(rx_valid), 0);
        idle(5);
        send_frame(8'h5A, 1'b1, -1);
        chk("after abort 0x5A", int'(rx_data), 'h5A);
        chk("after abort valid", int'(rx_valid), 1);

        sd0 = n_sd;
        serial_in = 1'b0;
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(10);
        serial_in = 1'b1;
        idle(10);
        chk("low line at reset release", n_sd - sd0, 0);

        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(0, 7) == 0) glitch();
                    else send_frame(8'($urandom), $urandom_range(0, 7) != 0, -1);
                    idle($urandom_range(0, 12));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    idle(1);
                    rx_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        idle(4);
        chk("model queue drained", q.size(), 0);

        running = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
